// File: rtl/top6_stream_selector.sv
// Streaming top-K selector: tags each accepted sample with its arrival index and
// keeps a descending list of the K largest {value, index} words.
module top6_stream_selector #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5,
    parameter int N      = 32,
    parameter int K      = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DATA_W-1:0]           in_data,
    output logic                               busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic        [K*(DATA_W+IDX_W)-1:0] out_list
);
    localparam int WORD_W = DATA_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [DATA_W-1:0]  r_val [K];
    logic        [IDX_W-1:0]   r_idx [K];
    logic        [K-1:0]       r_vld;
    logic        [IDX_W-1:0]   r_cnt;
    logic                      w_xfer;
    logic                      w_last;
    logic                      w_clear;
    logic        [K-1:0]       w_take;

    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign w_xfer    = in_valid && in_ready;
    assign w_last    = (r_cnt == IDX_W'(N - 1));
    assign w_clear   = (r_state == IDLE) && start;

    // Strict compare keeps the earlier word ahead on ties; the list is sorted,
    // so w_take is monotonic and its first set bit is the insertion rank.
    always_comb begin
        w_take = '0;
        for (int unsigned k = 0; k < K; k++) begin
            w_take[k] = !r_vld[k] || (r_val[k] < in_data);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    if (w_xfer && w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_vld <= '0;
            for (int unsigned k = 0; k < K; k++) begin
                r_val[k] <= '0;
                r_idx[k] <= '0;
            end
        end else if (w_clear) begin
            r_cnt <= '0;
            r_vld <= '0;
            for (int unsigned k = 0; k < K; k++) begin
                r_val[k] <= '0;
                r_idx[k] <= '0;
            end
        end else if (w_xfer) begin
            r_cnt <= r_cnt + IDX_W'(1);
            if (w_take[0]) begin
                r_val[0] <= in_data;
                r_idx[0] <= r_cnt;
                r_vld[0] <= 1'b1;
            end
            for (int unsigned k = 1; k < K; k++) begin
                if (w_take[k]) begin
                    if (!w_take[k-1]) begin
                        r_val[k] <= in_data;
                        r_idx[k] <= r_cnt;
                        r_vld[k] <= 1'b1;
                    end else begin
                        r_val[k] <= r_val[k-1];
                        r_idx[k] <= r_idx[k-1];
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        out_list = '0;
        for (int unsigned k = 0; k < K; k++) begin
            out_list[k*WORD_W +: WORD_W] = {r_val[k], r_idx[k]};
        end
    end

endmodule

// File: tb/tb_top6_stream_selector.sv
// Directed self-checking bench for top6_stream_selector with hand-computed
// expected top-6 lists.
module tb_top6_stream_selector;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
    localparam int N      = 32;
    localparam int K      = 6;
    localparam int LW     = K * (DATA_W + IDX_W);

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic        [LW-1:0]     out_list;

    int n_tests;
    int n_fail;
    int cyc;

    logic signed [7:0] fr [N];
    int                ev [K];
    int                ei [K];
    logic [LW-1:0]     exp_list;

    top6_stream_selector #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W),
        .N     (N),
        .K     (K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_list (out_list)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack6();
        logic [LW-1:0] res;
        logic [31:0]   v;
        logic [31:0]   ix;
        res = '0;
        for (int k = 0; k < K; k++) begin
            v  = ev[k];
            ix = ei[k];
            res[k*13 +: 13] = {v[7:0], ix[4:0]};
        end
        return res;
    endfunction

    // Starts a frame and feeds n_xfer samples from fr; mid_start >= 0 pulses
    // start again alongside that sample. Leaves the bench at a negedge.
    task automatic run_frame(input int n_xfer, input bit gaps, input int mid_start);
        int  i;
        int  guard;
        bit  early;
        i     = 0;
        guard = 0;
        early = 0;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (i < n_xfer && guard < 2000) begin
            guard++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = fr[i];
            start    = (i == mid_start) && in_valid;
            if (out_valid) early = 1;
            @(posedge clk);
            cyc++;
            if (in_valid && in_ready) i++;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("feed_complete", 128'(i), 128'(n_xfer));
        chk("no_early_valid", 128'(early), 128'(0));
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("accept_out_valid", 128'(out_valid), 128'(0));
        chk("accept_busy", 128'(busy), 128'(0));
    endtask

    task automatic set_ascending();
        for (int i = 0; i < N; i++) fr[i] = 8'(i);
        ev = '{31, 30, 29, 28, 27, 26};
        ei = '{31, 30, 29, 28, 27, 26};
        exp_list = pack6();
    endtask

    task automatic set_neg();
        for (int i = 0; i < N; i++) fr[i] = -8'sd100;
        fr[17] = -8'sd1;
        fr[3]  = -8'sd128;
        ev = '{-1, -100, -100, -100, -100, -100};
        ei = '{17, 0, 1, 2, 4, 5};
        exp_list = pack6();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_list", 128'(out_list), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Ascending frame with latency check
        set_ascending();
        run_frame(N, 0, -1);
        chk("asc_latency", 128'(cyc), 128'(33));
        chk("asc_out_valid", 128'(out_valid), 128'(1));
        chk("asc_in_ready_done", 128'(in_ready), 128'(0));
        chk("asc_busy_done", 128'(busy), 128'(1));
        chk("asc_list", 128'(out_list), 128'(exp_list));
        accept();
        chk("asc_list_held", 128'(out_list), 128'(exp_list));

        // All equal: earliest indices win
        for (int i = 0; i < N; i++) fr[i] = 8'sd5;
        ev = '{5, 5, 5, 5, 5, 5};
        ei = '{0, 1, 2, 3, 4, 5};
        exp_list = pack6();
        run_frame(N, 0, -1);
        chk("eq_out_valid", 128'(out_valid), 128'(1));
        chk("eq_list", 128'(out_list), 128'(exp_list));
        accept();

        // Negative values including -128
        set_neg();
        run_frame(N, 0, -1);
        chk("neg_list", 128'(out_list), 128'(exp_list));
        accept();

        // Descending with gaps and back-pressure
        for (int i = 0; i < N; i++) fr[i] = 8'(127 - i);
        ev = '{127, 126, 125, 124, 123, 122};
        ei = '{0, 1, 2, 3, 4, 5};
        exp_list = pack6();
        run_frame(N, 1, -1);
        for (int c = 0; c < 10; c++) begin
            chk("desc_hold_valid", 128'(out_valid), 128'(1));
            chk("desc_hold_list", 128'(out_list), 128'(exp_list));
            @(negedge clk);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("desc_idle_busy", 128'(busy), 128'(0));
        chk("desc_idle_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("desc_start_ignored", 128'(busy), 128'(0));
        chk("desc_list_kept", 128'(out_list), 128'(exp_list));

        // Reset mid-frame, then a clean ascending frame
        set_ascending();
        run_frame(12, 0, -1);
        chk("mid_busy_before_rst", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_list", 128'(out_list), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_frame(N, 0, -1);
        chk("rst_asc_latency", 128'(cyc), 128'(33));
        chk("rst_asc_list", 128'(out_list), 128'(exp_list));
        accept();

        // start pulsed during LOAD and during DONE
        set_neg();
        run_frame(N, 0, 10);
        chk("mid_start_latency", 128'(cyc), 128'(33));
        chk("mid_start_list", 128'(out_list), 128'(exp_list));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("done_start_valid", 128'(out_valid), 128'(1));
        chk("done_start_list", 128'(out_list), 128'(exp_list));
        accept();
        chk("final_list_kept", 128'(out_list), 128'(exp_list));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top6_stream_selector.md
Name: top6_stream_selector

Overview:
- Consumes a frame of N signed 8-bit samples over a valid/ready stream.
- Tags each sample with its 5-bit arrival index, forming the same 13-bit {value, index} word the max comparator stage uses.
- Maintains a running descending list of the K largest words by single-cycle insertion, then presents the packed list as the frame result.
- Sits downstream of the sample source and feeds the top-6 result consumer.

Parameters:
- DATA_W, 8, signed sample width (value field, bits [12:5] of a word)
- IDX_W, 5, index width (bits [4:0] of a word)
- N, 32, samples per frame; must satisfy K <= N <= 2**IDX_W
- K, 6, number of retained entries

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- in_valid  in  1  sample valid
- in_ready  out  1  high only in LOAD
- in_data  in  DATA_W  signed sample
- busy  out  1  high in LOAD and DONE
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  result accept
- out_list  out  K*(DATA_W+IDX_W)  rank k occupies bits [13k+12:13k]; rank 0 is the largest

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=0, busy=0, out_valid=0, out_list=0, all K entry-valid flags=0, sample counter=0.
- Word formed per sample: {in_data, cnt}, where cnt is the accepted-sample count 0..N-1.
- States and transitions:
  - IDLE -> LOAD on start=1. Same edge clears entries, entry-valid flags and cnt.
  - LOAD: a transfer occurs when in_valid & in_ready. On a transfer, cnt increments.
  - LOAD -> DONE on the edge that accepts sample N-1.
  - DONE: out_valid=1. DONE -> IDLE on out_valid & out_ready.
- Insertion on each transfer, completed at that clock edge:
  - Compare signed values only; index bits do not take part.
  - The new word takes the first rank r where the entry is invalid, or where entry.value < new.value (strict).
  - Ranks r..K-2 shift down one place; the rank K-1 word is discarded.
  - If no such rank exists, the list is unchanged.
  - Ties: the existing (earlier) word keeps the higher rank, matching comparator tie semantics where a is kept when a >= b.
- Latency: out_valid rises the cycle after the N-th transfer. out_list is stable and fully valid whenever out_valid=1. No combinational path from in_* to out_*.
- out_list keeps its final value after handshake until the next start clears it.
- start while busy: ignored, with no effect on the frame.
- in_valid outside LOAD: ignored; in_ready=0 there.
- in_valid gaps inside LOAD: no state change.
- Back-to-back frames: start may be asserted in the same cycle as the out_valid/out_ready handshake. It is ignored, because the state is not yet IDLE; it must be re-sent in IDLE.
- Reset asserted mid-frame or mid-DONE: immediate return to IDLE; partial results are lost.
- Signed extremes: -128 and 127 compare correctly with no overflow, since no arithmetic is performed, only signed compare.

Test Plan:
- Ascending frame, samples 0..31, in_valid held 1 -> out_valid 33 cycles after start; ranks 0..5 = {31,31},{30,30},{29,29},{28,28},{27,27},{26,26}.
- All samples = 5 -> ranks 0..5 hold value 5 with indices 0,1,2,3,4,5 (earlier index wins ties).
- All samples -100 except idx 17 = -1 and idx 3 = -128 -> rank 0 = {-1,17}; ranks 1..5 = {-100,0},{-100,1},{-100,2},{-100,4},{-100,5}.
- Descending 127..96, random in_valid gaps, out_ready held 0 for 10 cycles -> list = {127,0}..{122,5}; out_valid and out_list stable until out_ready; then IDLE, busy=0.
- rst pulsed after 12 transfers, then a new start with an ascending frame -> all outputs 0 immediately on reset; the second frame result matches the ascending-frame case exactly.
- start pulsed during LOAD and during DONE -> no effect; cnt and list are unaltered.
